// File: rtl/sysu_74ls165_pkg.sv
`timescale 1ns/1ps
// Shared control-decode types for the sysu_74ls165 parallel-in/serial-out shift register.
package sysu_74ls165_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD    = 2'b00,
        MODE_HOLD    = 2'b01,
        MODE_SHIFT   = 2'b10,
        MODE_UNKNOWN = 2'b11
    } mode_e;

    // Any unknown on SH_LD_N or CLK_INH falls through to MODE_UNKNOWN, which poisons every stage.
    function automatic mode_e decode_mode(input logic sh_ld_n, input logic clk_inh);
        mode_e m;
        case ({sh_ld_n, clk_inh})
            2'b00, 2'b01: m = MODE_LOAD;
            2'b11:        m = MODE_HOLD;
            2'b10:        m = MODE_SHIFT;
            default:      m = MODE_UNKNOWN;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sysu_165_stage.sv
`timescale 1ns/1ps
// One bit of the 74LS165 register: flip-flop with async clear and a load/hold/shift next-state mux.
module sysu_165_stage
    import sysu_74ls165_pkg::*;
(
    input  logic  clk,
    input  logic  clr_n,
    input  mode_e mode,
    input  logic  load_bit,
    input  logic  shift_bit,
    output logic  q
);

    logic q_r;
    logic d_next_s;

    // Next-state select for this stage.
    always_comb begin
        d_next_s = q_r;
        case (mode)
            MODE_LOAD:  d_next_s = load_bit;
            MODE_HOLD:  d_next_s = q_r;
            MODE_SHIFT: d_next_s = shift_bit;
            default:    d_next_s = 1'bx;
        endcase
    end

    // Stage flop; clear is asynchronous and dominates the clock.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_r <= 1'b0;
        end else begin
            q_r <= d_next_s;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/sysu_74ls165.sv
`timescale 1ns/1ps
// Parallel-in/serial-out shift register modelled on the 74LS165: MSB-first out on QH,
// SER feeds stage 0 for cascading, CLK_INH suppresses shifting, CLR_N clears asynchronously.
module sysu_74ls165
    import sysu_74ls165_pkg::*;
#(
    parameter int Delay = 0,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             SH_LD_N,
    input  logic             CLK_INH,
    input  logic             SER,
    input  logic [WIDTH-1:0] D,
    output logic             QH,
    output logic             QH_N
);

    mode_e            mode_s;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] shift_in_s;

    // Decoded once so every stage sees the same (possibly poisoned) mode on an edge.
    assign mode_s     = decode_mode(SH_LD_N, CLK_INH);
    assign shift_in_s = {r_s[WIDTH-2:0], SER};

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        sysu_165_stage u_stage (
            .clk       (CLK),
            .clr_n     (CLR_N),
            .mode      (mode_s),
            .load_bit  (D[i]),
            .shift_bit (shift_in_s[i]),
            .q         (r_s[i])
        );
    end

    // Library-wide simulation propagation delay on the output pins only.
    assign #(Delay) QH   = r_s[WIDTH-1];
    assign #(Delay) QH_N = ~r_s[WIDTH-1];

endmodule
